pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Program-counter and instruction-fetch sequencer for the SingleCycleCPU.
- Holds the architectural PC and supplies PC4Out to the next-PC jump mux.
- Consumes the mux's selected next-PC, plus JumpCtrl/Branch to classify the transfer.
- Drives a req/ack handshake to instruction memory, presents each fetched instruction with a valid flag, and counts taken control transfers.

Parameters:
- bit_size, 32: PC, address and instruction width.
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- CNT_W, 16: width of the RedirectCount saturating counter.
- TIMEOUT, 16: max FETCH cycles awaiting IM_Ack; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- NextPC  in  bit_size  next PC selected by the jump mux
- JumpCtrl  in  2  00 seq, 01 j/jal, 10 jr/jalr, 11 beq/bne
- Branch  in  1  branch condition true
- Stall  in  1  consumer not ready; hold current instruction
- IM_Ack  in  1  instruction memory returns IM_Data this cycle
- IM_Data  in  bit_size  instruction word
- IM_Req  out  1  fetch request
- IM_Addr  out  bit_size  fetch address (= PC)
- PC  out  bit_size  current PC
- PC4Out  out  bit_size  PC+4, combinational
- Instr  out  bit_size  latched instruction
- InstrValid  out  1  Instr valid for PC
- AlignErr  out  1  one-cycle pulse: misaligned NextPC accepted
- RedirectCount  out  CNT_W  count of taken transfers
- Fault  out  1  sticky fetch timeout (0 when feature compiled out)

Behaviour:
- Reset (rst=0, asynchronous):
  - PC=RESET_PC; Instr=0; InstrValid=0; IM_Req=0; AlignErr=0; RedirectCount=0; Fault=0; state=BOOT.
- PC4Out = PC+4 mod 2^bit_size; wraps from 32'hFFFF_FFFC to 0.
- IM_Addr = PC at all times.
- BOOT: one cycle after reset release -> FETCH.
- FETCH:
  - IM_Req=1.
  - On IM_Ack=1: Instr<=IM_Data, InstrValid<=1, IM_Req<=0 next cycle, -> ISSUE.
  - IM_Ack=0: remain in FETCH, IM_Req held high. Stall is ignored in FETCH.
  - IM_Ack while not in FETCH: ignored.
  - Minimum fetch latency: 1 cycle from IM_Req rise to InstrValid.
- ISSUE:
  - InstrValid=1, Instr stable.
  - Stall=1: hold everything.
  - Stall=0, at the clock edge:
    - PC<={NextPC[bit_size-1:2],2'b00}; InstrValid<=0; -> FETCH.
    - If NextPC[1:0]!=0, AlignErr=1 for the next cycle only.
    - Taken = (JumpCtrl==01) | (JumpCtrl==10) | (JumpCtrl==11 & Branch). If taken, RedirectCount++, saturating at all-ones.
    - JumpCtrl==11 with Branch=0 is not taken.
- Throughput without stalls or memory wait: one instruction per 2 cycles (ISSUE, FETCH).
- Reset asserted mid-fetch aborts immediately: IM_Req drops asynchronously and any in-flight ack is discarded.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - Cycle counter clears on entry to FETCH and increments each FETCH cycle without ack.
  - On reaching TIMEOUT: Fault<=1 (sticky until reset), IM_Req<=0, -> HALT.
  - HALT: InstrValid=0; no further fetches or PC updates.
- Undefined: no counter, no HALT state; Fault tied 0; FETCH waits indefinitely.

Test Plan:
- Reset release, IM_Ack immediately, Stall=0, JumpCtrl=00, NextPC=PC4Out -> PC sequence 0,4,8,12; InstrValid high every 2nd cycle; RedirectCount=0.
- In ISSUE with PC=0x10: JumpCtrl=11, Branch=1, NextPC=0x40 -> PC=0x40, RedirectCount=1. Repeat with Branch=0, NextPC=0x44 -> PC=0x44, count unchanged.
- Stall=1 for 5 cycles in ISSUE with Instr=0x8C01_0004 -> Instr/PC/InstrValid constant throughout; advances on the first Stall=0 edge.
- JumpCtrl=10, NextPC=0x0000_0103 -> PC=0x100, AlignErr pulses once, RedirectCount increments.
- PC=0xFFFF_FFFC -> PC4Out=0. With IM_Ack withheld 3 cycles, IM_Req stays high, then InstrValid follows the ack. Assert rst mid-FETCH -> all outputs at reset values.
- FETCH_TIMEOUT_EN, TIMEOUT=16, IM_Ack never asserted -> Fault=1 after 16 FETCH cycles, IM_Req=0, PC frozen until reset.

Source files
------------

// File: rtl/pc_fetch_ctrl_if.sv
// rtl/pc_fetch_ctrl_if.sv - fetch-sequencer signal bundle
//
// Groups every non-clock/reset signal of pc_fetch_ctrl.
//   slave  : the fetch sequencer side (pc_fetch_ctrl)
//   master : the environment side (datapath, instruction memory)
// Signals:
//   NextPC, JumpCtrl, Branch  - next-PC choice and its transfer class
//   Stall                     - consumer not ready, hold the instruction
//   IM_Req/IM_Addr/IM_Ack/IM_Data - instruction memory handshake
//   PC, PC4Out, Instr, InstrValid - architectural PC and issued instruction
//   AlignErr, RedirectCount, Fault - status
interface pc_fetch_ctrl_if #(
  parameter int bit_size = 32,
  parameter int CNT_W    = 16
);
  logic [bit_size-1:0] NextPC;
  logic [1:0]          JumpCtrl;
  logic                Branch;
  logic                Stall;
  logic                IM_Ack;
  logic [bit_size-1:0] IM_Data;
  logic                IM_Req;
  logic [bit_size-1:0] IM_Addr;
  logic [bit_size-1:0] PC;
  logic [bit_size-1:0] PC4Out;
  logic [bit_size-1:0] Instr;
  logic                InstrValid;
  logic                AlignErr;
  logic [CNT_W-1:0]    RedirectCount;
  logic                Fault;

  modport slave (
    input  NextPC, JumpCtrl, Branch, Stall, IM_Ack, IM_Data,
    output IM_Req, IM_Addr, PC, PC4Out, Instr, InstrValid,
           AlignErr, RedirectCount, Fault
  );

  modport master (
    output NextPC, JumpCtrl, Branch, Stall, IM_Ack, IM_Data,
    input  IM_Req, IM_Addr, PC, PC4Out, Instr, InstrValid,
           AlignErr, RedirectCount, Fault
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - program counter and instruction fetch sequencer
//
// Holds the PC, fetches one instruction per PC over a req/ack handshake,
// presents it with a valid flag and advances to NextPC when the consumer
// is not stalled. Taken transfers are counted in a saturating counter.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - pc_fetch_ctrl_if.slave (see interface file for signal list)
//
// Optional feature: define FETCH_TIMEOUT_EN to bound the FETCH wait to
// TIMEOUT cycles; on expiry Fault is set (sticky) and the sequencer parks
// in HALT until reset. Without the macro Fault is tied 0 and FETCH waits
// indefinitely.
module pc_fetch_ctrl #(
  parameter int                  bit_size = 32,
  parameter logic [bit_size-1:0] RESET_PC = '0,
  parameter int                  CNT_W    = 16,
  parameter int                  TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             rst,
  pc_fetch_ctrl_if.slave   bus
);

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_ISSUE, S_HALT} state_t;
  localparam int TW = $clog2(TIMEOUT + 1);
`else
  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_ISSUE} state_t;
`endif

  // Low bits forced to zero so a misconfigured RESET_PC cannot start unaligned.
  localparam logic [bit_size-1:0] RESET_PC_W = {RESET_PC[bit_size-1:2], 2'b00};
  localparam logic [CNT_W-1:0]    CNT_MAX    = {CNT_W{1'b1}};

  state_t              state_q, state_d;
  logic [bit_size-1:0] pc_q, pc_d;
  logic [bit_size-1:0] instr_q, instr_d;
  logic                valid_q, valid_d;
  logic                align_q, align_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                taken;

`ifdef FETCH_TIMEOUT_EN
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                fault_q, fault_d;
`endif

  assign taken = (bus.JumpCtrl == 2'b01) ||
                 (bus.JumpCtrl == 2'b10) ||
                 ((bus.JumpCtrl == 2'b11) && bus.Branch);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    align_d = 1'b0;   // AlignErr is a single-cycle pulse
    cnt_d   = cnt_q;
`ifdef FETCH_TIMEOUT_EN
    tmo_d   = tmo_q;
    fault_d = fault_q;
`endif
    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
`ifdef FETCH_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_FETCH: begin
        if (bus.IM_Ack) begin
          instr_d = bus.IM_Data;
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th cycle without an ack.
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_ISSUE: begin
        if (!bus.Stall) begin
          pc_d    = {bus.NextPC[bit_size-1:2], 2'b00};
          align_d = |bus.NextPC[1:0];
          valid_d = 1'b0;
          state_d = S_FETCH;
          if (taken && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
          end
`ifdef FETCH_TIMEOUT_EN
          tmo_d = '0;
`endif
        end
      end
`ifdef FETCH_TIMEOUT_EN
      S_HALT: begin
        valid_d = 1'b0;
      end
`endif
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC_W;
      instr_q <= '0;
      valid_q <= 1'b0;
      align_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      align_q <= align_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      tmo_q   <= tmo_d;
      fault_q <= fault_d;
    end
  end
  assign bus.Fault = fault_q;
`else
  assign bus.Fault = 1'b0;
`endif

  // Request is decoded from the state register, so an asynchronous reset
  // drops it immediately and any ack arriving during reset is ignored.
  assign bus.IM_Req        = (state_q == S_FETCH);
  assign bus.IM_Addr       = pc_q;
  assign bus.PC            = pc_q;
  assign bus.PC4Out        = pc_q + bit_size'(4);
  assign bus.Instr         = instr_q;
  assign bus.InstrValid    = valid_q;
  assign bus.AlignErr      = align_q;
  assign bus.RedirectCount = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - self-checking bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;
  localparam int CW = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pc_fetch_ctrl_if #(.bit_size(32), .CNT_W(CW)) ifc ();

  pc_fetch_ctrl #(
    .bit_size(32), .RESET_PC(32'h0), .CNT_W(CW), .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        stall;
    logic        ack;
    logic [31:0] data;
    logic [31:0] npc;
    logic [1:0]  jc;
    logic        br;
    logic [31:0] e_pc;
    logic        e_req;
    logic        e_valid;
    logic        e_align;
    logic [31:0] e_instr;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic s, logic a, logic [31:0] d, logic [31:0] n,
                              logic [1:0] j, logic b, logic [31:0] pc, logic rq,
                              logic v, logic al, logic [31:0] ins, logic [31:0] c);
    vec_t r;
    r.stall = s; r.ack = a; r.data = d; r.npc = n; r.jc = j; r.br = b;
    r.e_pc = pc; r.e_req = rq; r.e_valid = v; r.e_align = al;
    r.e_instr = ins; r.e_cnt = c;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic rq,
                         input logic v, input logic al, input logic [31:0] ins,
                         input logic [31:0] c, input logic flt);
    chk({tag, ".PC"},         ifc.PC, pc);
    chk({tag, ".IM_Addr"},    ifc.IM_Addr, pc);
    chk({tag, ".PC4Out"},     ifc.PC4Out, pc + 32'd4);
    chk({tag, ".IM_Req"},     32'(ifc.IM_Req), 32'(rq));
    chk({tag, ".InstrValid"}, 32'(ifc.InstrValid), 32'(v));
    chk({tag, ".AlignErr"},   32'(ifc.AlignErr), 32'(al));
    chk({tag, ".Instr"},      ifc.Instr, ins);
    chk({tag, ".RedirCnt"},   32'(ifc.RedirectCount), c);
    chk({tag, ".Fault"},      32'(ifc.Fault), 32'(flt));
  endtask

  task automatic drive(input logic s, input logic a, input logic [31:0] d,
                       input logic [31:0] n, input logic [1:0] j, input logic b);
    ifc.Stall = s; ifc.IM_Ack = a; ifc.IM_Data = d;
    ifc.NextPC = n; ifc.JumpCtrl = j; ifc.Branch = b;
  endtask

  // Reference model state (transaction level: booting, holding an instruction or not)
  logic        m_boot, m_have, m_align;
  logic [31:0] m_pc, m_instr, m_cnt;
  int          m_wait;

  initial begin
    logic        s, a, b;
    logic [31:0] d, n;
    logic [1:0]  j;
    checks = 0;
    failures = 0;
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);

    // Directed table, starting from reset release
    tbl.push_back(mk(0,1,32'hDEAD0001,32'h0,  2'b00,0, 32'h0, 1,0,0,32'h0,        0));
    tbl.push_back(mk(0,1,32'h11,      32'h0,  2'b00,0, 32'h0, 0,1,0,32'h11,       0));
    tbl.push_back(mk(0,0,32'h0,       32'h4,  2'b00,0, 32'h4, 1,0,0,32'h11,       0));
    tbl.push_back(mk(0,1,32'h22,      32'h4,  2'b00,0, 32'h4, 0,1,0,32'h22,       0));
    tbl.push_back(mk(0,0,32'h0,       32'h8,  2'b00,0, 32'h8, 1,0,0,32'h22,       0));
    tbl.push_back(mk(0,1,32'h33,      32'h8,  2'b00,0, 32'h8, 0,1,0,32'h33,       0));
    tbl.push_back(mk(0,0,32'h0,       32'hC,  2'b00,0, 32'hC, 1,0,0,32'h33,       0));
    tbl.push_back(mk(0,1,32'h44,      32'hC,  2'b00,0, 32'hC, 0,1,0,32'h44,       0));
    tbl.push_back(mk(0,0,32'h0,       32'h10, 2'b00,0, 32'h10,1,0,0,32'h44,       0));
    tbl.push_back(mk(0,1,32'h55,      32'h10, 2'b00,0, 32'h10,0,1,0,32'h55,       0));
    tbl.push_back(mk(0,0,32'h0,       32'h40, 2'b11,1, 32'h40,1,0,0,32'h55,       1));
    tbl.push_back(mk(0,1,32'h66,      32'h40, 2'b00,0, 32'h40,0,1,0,32'h66,       1));
    tbl.push_back(mk(0,0,32'h0,       32'h44, 2'b11,0, 32'h44,1,0,0,32'h66,       1));
    tbl.push_back(mk(0,1,32'h8C010004,32'h44, 2'b00,0, 32'h44,0,1,0,32'h8C010004, 1));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1,1,32'h12345678,32'h200,2'b01,0, 32'h44,0,1,0,32'h8C010004, 1));
    tbl.push_back(mk(0,0,32'h0,       32'h200,2'b01,0, 32'h200,1,0,0,32'h8C010004,2));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(k[0],0,32'h99, 32'h300,2'b01,0, 32'h200,1,0,0,32'h8C010004,2));
    tbl.push_back(mk(1,1,32'h77,      32'h300,2'b01,0, 32'h200,0,1,0,32'h77,       2));
    tbl.push_back(mk(0,0,32'h0,       32'h103,2'b10,0, 32'h100,1,0,1,32'h77,       3));
    tbl.push_back(mk(0,1,32'h88,      32'h0,  2'b00,0, 32'h100,0,1,0,32'h88,       3));
    tbl.push_back(mk(0,0,32'h0,  32'hFFFFFFFC,2'b01,0, 32'hFFFFFFFC,1,0,0,32'h88,  4));
    tbl.push_back(mk(0,0,32'h0,       32'h0,  2'b00,0, 32'hFFFFFFFC,1,0,0,32'h88,  4));

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 32'h0, 0, 0, 0, 32'h0, 0, 0);
    rst = 1'b1;
    #1;
    chk("boot.IM_Req", 32'(ifc.IM_Req), 32'h0);

    foreach (tbl[i]) begin
      drive(tbl[i].stall, tbl[i].ack, tbl[i].data, tbl[i].npc, tbl[i].jc, tbl[i].br);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_req, tbl[i].e_valid,
              tbl[i].e_align, tbl[i].e_instr, tbl[i].e_cnt, 1'b0);
    end

    // Reset in the middle of FETCH, with an ack arriving meanwhile
    #2;
    rst = 1'b0;
    ifc.IM_Ack = 1'b1;
    ifc.IM_Data = 32'hBAD0BAD0;
    #1;
    chk_all("midrst", 32'h0, 0, 0, 0, 32'h0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("inrst", 32'h0, 0, 0, 0, 32'h0, 0, 0);
    ifc.IM_Ack = 1'b0;
    rst = 1'b1;

    // Randomized run against the transaction-level model
    m_boot = 1; m_have = 0; m_align = 0; m_pc = 0; m_instr = 0; m_cnt = 0; m_wait = 0;
    for (int i = 0; i < 1500; i++) begin
      s = ($urandom_range(0, 9) < 3);
      a = $urandom_range(0, 1);
      d = $urandom;
      j = 2'($urandom_range(0, 3));
      b = $urandom_range(0, 1);
      n = ($urandom_range(0, 1) == 1) ? m_pc + 32'd4 : $urandom;
      if (!m_boot && !m_have && m_wait >= 8) a = 1'b1;
      drive(s, a, d, n, j, b);
      @(posedge clk);
      m_align = 1'b0;
      if (m_boot) begin
        m_boot = 1'b0;
        m_wait = 0;
      end else if (!m_have) begin
        if (a) begin
          m_have = 1'b1;
          m_instr = d;
        end else begin
          m_wait++;
        end
      end else if (!s) begin
        m_pc = n & 32'hFFFF_FFFC;
        m_align = (n % 4) != 0;
        if (((j == 2'd1) || (j == 2'd2) || (j == 2'd3 && b)) && m_cnt < (2**CW - 1))
          m_cnt = m_cnt + 1;
        m_have = 1'b0;
        m_wait = 0;
      end
      #1;
      chk_all($sformatf("rnd%0d", i), m_pc, !m_have, m_have, m_align, m_instr, m_cnt, 1'b0);
    end

`ifdef FETCH_TIMEOUT_EN
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h40, 2'b01, 1'b0);
    @(posedge clk);   // BOOT -> FETCH
    for (int k = 1; k < 16; k++) begin
      @(posedge clk);
    end
    #1;
    chk("tmo.pre.Fault", 32'(ifc.Fault), 32'h0);
    chk("tmo.pre.IM_Req", 32'(ifc.IM_Req), 32'h1);
    @(posedge clk);
    #1;
    chk("tmo.Fault", 32'(ifc.Fault), 32'h1);
    chk("tmo.IM_Req", 32'(ifc.IM_Req), 32'h0);
    drive(1'b0, 1'b1, 32'h5, 32'h80, 2'b01, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("halt.Fault", 32'(ifc.Fault), 32'h1);
    chk("halt.PC", ifc.PC, 32'h0);
    chk("halt.IM_Req", 32'(ifc.IM_Req), 32'h0);
    chk("halt.InstrValid", 32'(ifc.InstrValid), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
